// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and defaults for the memory port arbiter
package cpu_bus_pkg;

  localparam int DEF_AW          = 32;
  localparam int DEF_DW          = 32;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Grant vector bit 0 is IF, bit 1 is LS.
  function automatic owner_e gnt_to_owner(input logic [1:0] gnt);
    return (gnt == 2'b10) ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker, combinational, one-hot-or-zero grant
module rr_arb2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_e     i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   o_gnt = (i_last == OWN_LS) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// One outstanding transaction, round-robin grant, response-timeout watchdog.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            i_if_req_valid,
  output logic            o_if_req_ready,
  input  logic [AW-1:0]   i_if_req_addr,
  output logic            o_if_rsp_valid,
  output logic [DW-1:0]   o_if_rsp_rdata,
  output logic            o_if_rsp_err,

  input  logic            i_ls_req_valid,
  output logic            o_ls_req_ready,
  input  logic [AW-1:0]   i_ls_req_addr,
  input  logic            i_ls_req_we,
  input  logic [DW/8-1:0] i_ls_req_wstrb,
  input  logic [DW-1:0]   i_ls_req_wdata,
  output logic            o_ls_rsp_valid,
  output logic [DW-1:0]   o_ls_rsp_rdata,
  output logic            o_ls_rsp_err,

  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [AW-1:0]   o_mem_req_addr,
  output logic            o_mem_req_we,
  output logic [DW/8-1:0] o_mem_req_wstrb,
  output logic [DW-1:0]   o_mem_req_wdata,
  input  logic            i_mem_rsp_valid,
  input  logic [DW-1:0]   i_mem_rsp_rdata,

  output logic            o_arb_busy,
  output logic            o_stray_rsp
);

  localparam int            CW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit            WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_e        r_state;
  owner_e            r_owner;
  owner_e            r_last_grant;
  logic [AW-1:0]     r_addr;
  logic              r_we;
  logic [DW/8-1:0]   r_wstrb;
  logic [DW-1:0]     r_wdata;
  logic              r_mem_req_valid;
  logic [CW-1:0]     r_cnt;
  logic              r_if_rsp_valid;
  logic              r_ls_rsp_valid;
  logic              r_rsp_err;
  logic [DW-1:0]     r_rsp_rdata;
  logic              r_stray_rsp;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  owner_e            w_win;
  logic              w_accept;
  logic              w_timeout;
  logic              w_rsp_ok;
  logic              w_to_err;

  assign w_req = {i_ls_req_valid, i_if_req_valid};

  rr_arb2 u_rr_arb2 (
    .i_req  (w_req),
    .i_last (r_last_grant),
    .o_gnt  (w_gnt)
  );

  assign w_win    = gnt_to_owner(w_gnt);
  assign w_accept = (r_state == IDLE) && (w_gnt != 2'b00);

  assign o_if_req_ready = (r_state == IDLE) && w_gnt[0];
  assign o_ls_req_ready = (r_state == IDLE) && w_gnt[1];

  // r_cnt holds the number of ISSUE/WAIT cycles already spent on this transaction.
  assign w_timeout = WD_EN && (r_state != IDLE) && (r_cnt == TO_VAL);
  assign w_rsp_ok  = (r_state == WAIT) && i_mem_rsp_valid;
  assign w_to_err  = w_timeout && !w_rsp_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_owner         <= OWN_IF;
      r_last_grant    <= OWN_LS;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_wstrb         <= '0;
      r_wdata         <= '0;
      r_mem_req_valid <= 1'b0;
      r_cnt           <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_ls_rsp_valid  <= 1'b0;
      r_rsp_err       <= 1'b0;
      r_rsp_rdata     <= '0;
      r_stray_rsp     <= 1'b0;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_rdata    <= '0;

      if (i_mem_rsp_valid && (r_state != WAIT)) begin
        r_stray_rsp <= 1'b1;
      end

      if ((r_state != IDLE) && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner      <= w_win;
            r_last_grant <= w_win;
            if (w_win == OWN_IF) begin
              r_addr  <= i_if_req_addr;
              r_we    <= 1'b0;
              r_wstrb <= '0;
              r_wdata <= '0;
            end else begin
              r_addr  <= i_ls_req_addr;
              r_we    <= i_ls_req_we;
              r_wstrb <= i_ls_req_wstrb;
              r_wdata <= i_ls_req_wdata;
            end
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!w_to_err && i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: ;
        default: r_state <= IDLE;
      endcase

      // Normal completion or watchdog expiry; a response in the expiry cycle wins.
      if (w_rsp_ok || w_to_err) begin
        r_state         <= IDLE;
        r_mem_req_valid <= 1'b0;
        r_if_rsp_valid  <= (r_owner == OWN_IF);
        r_ls_rsp_valid  <= (r_owner == OWN_LS);
        r_rsp_err       <= w_to_err;
        r_rsp_rdata     <= (w_rsp_ok && !r_we) ? i_mem_rsp_rdata : '0;
      end
    end
  end

  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_we    = r_we;
  assign o_mem_req_wstrb = r_wstrb;
  assign o_mem_req_wdata = r_wdata;

  assign o_if_rsp_valid  = r_if_rsp_valid;
  assign o_if_rsp_rdata  = r_rsp_rdata;
  assign o_if_rsp_err    = r_rsp_err;
  assign o_ls_rsp_valid  = r_ls_rsp_valid;
  assign o_ls_rsp_rdata  = r_rsp_rdata;
  assign o_ls_rsp_err    = r_rsp_err;

  assign o_arb_busy  = (r_state != IDLE);
  assign o_stray_rsp = r_stray_rsp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_v;
  logic        if_ready;
  logic [31:0] if_addr;
  logic        if_rsp_v;
  logic [31:0] if_rsp_rdata;
  logic        if_rsp_err;
  logic        ls_v;
  logic        ls_ready;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_wdata;
  logic        ls_rsp_v;
  logic [31:0] ls_rsp_rdata;
  logic        ls_rsp_err;
  logic        mem_v;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_v;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        stray;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_if_req_valid  (if_v),
    .o_if_req_ready  (if_ready),
    .i_if_req_addr   (if_addr),
    .o_if_rsp_valid  (if_rsp_v),
    .o_if_rsp_rdata  (if_rsp_rdata),
    .o_if_rsp_err    (if_rsp_err),
    .i_ls_req_valid  (ls_v),
    .o_ls_req_ready  (ls_ready),
    .i_ls_req_addr   (ls_addr),
    .i_ls_req_we     (ls_we),
    .i_ls_req_wstrb  (ls_wstrb),
    .i_ls_req_wdata  (ls_wdata),
    .o_ls_rsp_valid  (ls_rsp_v),
    .o_ls_rsp_rdata  (ls_rsp_rdata),
    .o_ls_rsp_err    (ls_rsp_err),
    .o_mem_req_valid (mem_v),
    .i_mem_req_ready (mem_ready),
    .o_mem_req_addr  (mem_addr),
    .o_mem_req_we    (mem_we),
    .o_mem_req_wstrb (mem_wstrb),
    .o_mem_req_wdata (mem_wdata),
    .i_mem_rsp_valid (mem_rsp_v),
    .i_mem_rsp_rdata (mem_rdata),
    .o_arb_busy      (busy),
    .o_stray_rsp     (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; if_v = 1'b0; if_addr = '0;
    ls_v = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_wstrb = '0; ls_wdata = '0;
    mem_ready = 1'b0; mem_rsp_v = 1'b0; mem_rdata = '0;
    tick();
    tick();

    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_valid", mem_v, 1'b0);
    chk1("rst_if_rsp", if_rsp_v, 1'b0);
    chk1("rst_ls_rsp", ls_rsp_v, 1'b0);
    chk1("rst_stray", stray, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_ls_ready", ls_ready, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_if_rdata", if_rsp_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Both requesters always valid: IF, LS, IF, LS at one accept every 3 cycles.
    if_v = 1'b1; if_addr = 32'h400;
    ls_v = 1'b1; ls_we = 1'b0; ls_addr = 32'h800;
    for (int k = 0; k < 4; k++) begin
      logic exp_ls;
      exp_ls = k[0];
      #1;
      chk1("rr_if_ready", if_ready, !exp_ls);
      chk1("rr_ls_ready", ls_ready, exp_ls);
      tick();
      mem_ready = 1'b1;
      #1;
      chk1("rr_mem_valid", mem_v, 1'b1);
      chk32("rr_mem_addr", mem_addr, exp_ls ? 32'h800 : 32'h400);
      tick();
      mem_ready = 1'b0; mem_rsp_v = 1'b1; mem_rdata = 32'h1000 + k;
      tick();
      mem_rsp_v = 1'b0;
      #1;
      chk1("rr_if_rsp", if_rsp_v, !exp_ls);
      chk1("rr_ls_rsp", ls_rsp_v, exp_ls);
      chk32("rr_rdata", exp_ls ? ls_rsp_rdata : if_rsp_rdata, 32'h1000 + k);
    end
    if_v = 1'b0; ls_v = 1'b0;
    tick();
    chk1("rr_rsp_one_cycle", ls_rsp_v, 1'b0);

    // LS write: read data must come back as zero.
    ls_v = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wstrb = 4'b0011; ls_wdata = 32'hDEADBEEF;
    #1;
    chk1("wr_ls_ready", ls_ready, 1'b1);
    chk1("wr_if_ready", if_ready, 1'b0);
    tick();
    ls_v = 1'b0; ls_we = 1'b0; ls_wstrb = '0; ls_wdata = '0; mem_ready = 1'b1;
    #1;
    chk1("wr_mem_valid", mem_v, 1'b1);
    chk32("wr_mem_addr", mem_addr, 32'h200);
    chk1("wr_mem_we", mem_we, 1'b1);
    chk32("wr_mem_wstrb", 32'(mem_wstrb), 32'h3);
    chk32("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    mem_ready = 1'b0; mem_rsp_v = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk1("wr_mem_valid_drop", mem_v, 1'b0);
    tick();
    mem_rsp_v = 1'b0;
    #1;
    chk1("wr_ls_rsp", ls_rsp_v, 1'b1);
    chk32("wr_ls_rdata", ls_rsp_rdata, 32'h0);
    chk1("wr_ls_err", ls_rsp_err, 1'b0);
    chk1("wr_if_rsp", if_rsp_v, 1'b0);
    tick();

    // IF read with memory stalling 5 cycles; write fields must read as zero.
    if_v = 1'b1; if_addr = 32'h300;
    #1;
    chk1("st_if_ready", if_ready, 1'b1);
    tick();
    if_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk1("st_mem_valid", mem_v, 1'b1);
      chk32("st_mem_addr", mem_addr, 32'h300);
      chk1("st_mem_we", mem_we, 1'b0);
      chk32("st_mem_wdata", mem_wdata, 32'h0);
      chk32("st_mem_wstrb", 32'(mem_wstrb), 32'h0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk1("st_mem_valid_last", mem_v, 1'b1);
    tick();
    mem_ready = 1'b0; mem_rsp_v = 1'b1; mem_rdata = 32'hA5A50300;
    tick();
    mem_rsp_v = 1'b0;
    #1;
    chk1("st_if_rsp", if_rsp_v, 1'b1);
    chk32("st_if_rdata", if_rsp_rdata, 32'hA5A50300);
    chk1("st_if_err", if_rsp_err, 1'b0);
    tick();

    // Watchdog: no response; counter hits 8 in the 9th ISSUE/WAIT cycle.
    ls_v = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
    #1;
    chk1("to_ls_ready", ls_ready, 1'b1);
    tick();
    ls_v = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk1("to_no_rsp_yet", ls_rsp_v, 1'b0);
      chk1("to_busy", busy, 1'b1);
      tick();
    end
    #1;
    chk1("to_ls_rsp", ls_rsp_v, 1'b1);
    chk1("to_ls_err", ls_rsp_err, 1'b1);
    chk32("to_ls_rdata", ls_rsp_rdata, 32'h0);
    chk1("to_busy_clear", busy, 1'b0);
    chk1("to_stray_before", stray, 1'b0);
    mem_rsp_v = 1'b1; mem_rdata = 32'h00000BAD;
    tick();
    mem_rsp_v = 1'b0;
    #1;
    chk1("to_stray_set", stray, 1'b1);
    chk1("to_late_not_fwd_ls", ls_rsp_v, 1'b0);
    chk1("to_late_not_fwd_if", if_rsp_v, 1'b0);
    tick();

    // Reset while waiting for the memory response.
    if_v = 1'b1; if_addr = 32'h600;
    tick();
    if_v = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk1("mr_busy_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mr_busy_rst", busy, 1'b0);
    chk1("mr_mem_valid_rst", mem_v, 1'b0);
    chk1("mr_stray_rst", stray, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk1("mr_no_if_rsp0", if_rsp_v, 1'b0);
    tick();
    chk1("mr_no_if_rsp1", if_rsp_v, 1'b0);
    if_v = 1'b1; if_addr = 32'h700;
    #1;
    chk1("mr_if_ready", if_ready, 1'b1);
    tick();
    if_v = 1'b0; mem_ready = 1'b1;
    #1;
    chk32("mr_mem_addr", mem_addr, 32'h700);
    tick();
    mem_ready = 1'b0; mem_rsp_v = 1'b1; mem_rdata = 32'h00007777;
    tick();
    mem_rsp_v = 1'b0;
    #1;
    chk1("mr_if_rsp", if_rsp_v, 1'b1);
    chk32("mr_if_rdata", if_rsp_rdata, 32'h00007777);
    chk1("mr_if_err", if_rsp_err, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
